// File: rtl/led_share_arbiter.sv
// Round-robin owner of a shared LED bank: minimum tenure before preemption,
// optional per-requester blink, registered LED drive.
module led_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LED_W       = 3,
  parameter int HOLD_CYCLES = 1000,
  parameter int BLINK_DIV   = 500
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LED_W-1:0]   req_pattern,
  input  logic [NUM_REQ-1:0]         req_blink,
  output logic [NUM_REQ-1:0]         grant,
  output logic [LED_W-1:0]           led_out,
  output logic                       busy
);

  // state    | meaning
  // S_IDLE   | no owner, outputs dark
  // S_OWNED  | owner_q holds the LEDs, hold/blink counters running
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OWNED = 1'b1;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [0:0]         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] cand;
  logic [IW:0]        scan_sum;
  logic [IW-1:0]      scan_idx;
  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic               take;

  // Current owner is masked out, so the scan from rr_ptr only sees waiters.
  always_comb begin
    cand = req;
    if (state_q == S_OWNED) cand[owner_q] = 1'b0;
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(NUM_REQ)) scan_sum = scan_sum - (IW+1)'(NUM_REQ);
      scan_idx = scan_sum[IW-1:0];
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    hold_d      = hold_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    take        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) take = 1'b1;
      end
      default: begin
        if (!req[owner_q]) begin
          if (win_found) begin
            take = 1'b1;
          end else begin
            state_d     = S_IDLE;
            hold_d      = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b1;
          end
        end else if (hold_q == HOLD_MAX && win_found) begin
          take = 1'b1;
        end else begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
          if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
      end
    endcase

    if (take) begin
      state_d     = S_OWNED;
      owner_d     = win_idx;
      hold_d      = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b1;
      rr_ptr_d    = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
    end
  end

  // Outputs are computed from the next state so they register with grant.
  always_comb begin
    grant_d = '0;
    led_d   = '0;
    busy_d  = 1'b0;
    if (state_d == S_OWNED) begin
      grant_d[owner_d] = 1'b1;
      busy_d           = 1'b1;
      led_d            = req_pattern[owner_d*LED_W +: LED_W];
      if (req_blink[owner_d]) led_d = led_d & {LED_W{phase_d}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      grant_q     <= '0;
      led_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      grant_q     <= grant_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
    end
  end

  assign grant   = grant_q;
  assign led_out = led_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Vector table plus hand sequences for led_share_arbiter; expected outputs
// go through a queue and are compared one cycle after being driven.
module tb_led_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] req_pattern;
  logic [3:0]  req_blink;
  logic [3:0]  grant;
  logic [2:0]  led_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  led_share_arbiter #(
    .NUM_REQ(4), .LED_W(3), .HOLD_CYCLES(4), .BLINK_DIV(2)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_pattern(req_pattern),
    .req_blink(req_blink), .grant(grant), .led_out(led_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert ($onehot0(grant)) else $error("grant not one-hot: %b", grant);
  end

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [11:0] pat;
    logic [3:0]  blk;
    logic [3:0]  g;
    logic [2:0]  led;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [2:0] led;
    int         id;
  } exp_t;

  // Patterns {p3,p2,p1,p0}
  localparam logic [11:0] PD  = 12'b110_101_010_001;
  localparam logic [11:0] P2B = 12'b110_010_010_001;
  localparam logic [11:0] P1W = 12'b110_101_111_001;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [11:0] pat,
                              input logic [3:0] blk, input logic [3:0] g, input logic [2:0] led);
    vec_t v;
    v.rst = rst; v.rq = rq; v.pat = pat; v.blk = blk; v.g = g; v.led = led;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    reset = v.rst; req = v.rq; req_pattern = v.pat; req_blink = v.blk;
    sb.push_back('{g: v.g, led: v.led, id: id});
    @(posedge clk);
    #1;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL step%0d scoreboard empty", id);
    end else begin
      e = sb.pop_front();
      if (grant !== e.g) begin
        bad++;
        $display("FAIL step%0d grant got=%b want=%b", e.id, grant, e.g);
      end
      total++;
      if (led_out !== e.led) begin
        bad++;
        $display("FAIL step%0d led_out got=%b want=%b", e.id, led_out, e.led);
      end
      total++;
      if (busy !== (|e.g)) begin
        bad++;
        $display("FAIL step%0d busy got=%b want=%b", e.id, busy, |e.g);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_pattern = PD; req_blink = '0;

    // reset with all requesting, then first grant to requester 0
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 4'b1111, PD, 0, 4'b0000, 3'b000));
    tbl.push_back(mk(0, 4'b1111, PD, 0, 4'b0001, 3'b001));
    tbl.push_back(mk(0, 4'b0000, PD, 0, 4'b0000, 3'b000));
    // single owner, live pattern update
    tbl.push_back(mk(0, 4'b0100, PD,  0, 4'b0100, 3'b101));
    tbl.push_back(mk(0, 4'b0100, P2B, 0, 4'b0100, 3'b010));
    tbl.push_back(mk(0, 4'b0000, PD,  0, 4'b0000, 3'b000));
    tbl.push_back(mk(1, 4'b0000, PD,  0, 4'b0000, 3'b000));
    // round robin with hold of 4
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b0011, PD, 0, 4'b0001, 3'b001));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b0011, PD, 0, 4'b0010, 3'b010));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b0011, PD, 0, 4'b0001, 3'b001));
    tbl.push_back(mk(0, 4'b0011, PD, 0, 4'b0010, 3'b010));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b1011, PD, 0, 4'b0010, 3'b010));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b1011, PD, 0, 4'b1000, 3'b110));
    tbl.push_back(mk(0, 4'b1011, PD, 0, 4'b0001, 3'b001));
    // release with direct handoff
    tbl.push_back(mk(0, 4'b0101, PD, 0, 4'b0001, 3'b001));
    tbl.push_back(mk(0, 4'b0100, PD, 0, 4'b0100, 3'b101));
    tbl.push_back(mk(0, 4'b0000, PD, 0, 4'b0000, 3'b000));
    // blink, half-period 2
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 4'b0010, P1W, 4'b0010, 4'b0010, ((i % 4) < 2) ? 3'b111 : 3'b000));
    tbl.push_back(mk(0, 4'b0000, P1W, 4'b0010, 4'b0000, 3'b000));
    tbl.push_back(mk(0, 4'b0010, P1W, 4'b0010, 4'b0010, 3'b111));
    tbl.push_back(mk(0, 4'b0010, P1W, 4'b0010, 4'b0010, 3'b111));
    tbl.push_back(mk(0, 4'b0010, P1W, 4'b0010, 4'b0010, 3'b000));
    // reset mid-tenure, then arbitration restarts at 0
    tbl.push_back(mk(1, 4'b0010, P1W, 4'b0010, 4'b0000, 3'b000));
    tbl.push_back(mk(0, 4'b1001, P1W, 4'b0010, 4'b0001, 3'b001));
    tbl.push_back(mk(1, 4'b0000, PD,  4'b0000, 4'b0000, 3'b000));

    foreach (tbl[i]) apply(tbl[i], i);

    // one-cycle pulse, then owner dropping exactly at hold expiry
    apply(mk(0, 4'b0100, PD, 0, 4'b0100, 3'b101), 100);
    apply(mk(0, 4'b0000, PD, 0, 4'b0000, 3'b000), 101);
    apply(mk(0, 4'b0001, PD, 0, 4'b0001, 3'b001), 102);
    for (int i = 0; i < 3; i++) apply(mk(0, 4'b0011, PD, 0, 4'b0001, 3'b001), 103 + i);
    apply(mk(0, 4'b0010, PD, 0, 4'b0010, 3'b010), 106);
    apply(mk(0, 4'b0000, PD, 0, 4'b0000, 3'b000), 107);
    // blink phase restarts on a preemptive handoff
    apply(mk(0, 4'b0001, PD, 4'b1111, 4'b0001, 3'b001), 108);
    apply(mk(0, 4'b0011, PD, 4'b1111, 4'b0001, 3'b001), 109);
    apply(mk(0, 4'b0011, PD, 4'b1111, 4'b0001, 3'b000), 110);
    apply(mk(0, 4'b0011, PD, 4'b1111, 4'b0001, 3'b000), 111);
    apply(mk(0, 4'b0011, PD, 4'b1111, 4'b0010, 3'b010), 112);
    apply(mk(0, 4'b0000, PD, 4'b1111, 4'b0000, 3'b000), 113);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard leftover got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
